collision_engine: RTL
=====================

// Module: collision_engine
// PURPOSE
//  Per-step collision/score judge for up to NUM_SNAKES snakes; successor to the fixed two-snake comb checker.
//  On a step pulse from the game FSM: latch next-step geometry, resolve head bumps, read one map tile per snake
//  through a 1-cycle-latency tile port, then emit per-snake eaten/died and a registered game verdict.
//  Sits between the snake movement logic and the game/score FSM; owns no map storage.
// PARAMETERS
//  NUM_SNAKES  2   snakes judged per step (2..4)
//  XW          6   x coordinate width
//  YW          5   y coordinate width
//  LW          8   snake length width
//  MAX_LEN     64  length that wins the game
// PORTS
//  clk           in   1           system clock
//  rst           in   1           synchronous, active-high reset
//  start         in   1           step pulse; accepted only in IDLE with game_active=1
//  game_active   in   1           mode==GAME; 0 => start ignored
//  alive_in      in   NUM_SNAKES  snakes still playing; dead snakes neither judged nor collidable by head/tail
//  head_x/head_y in   N*XW/N*YW   next-step head coords, snake i at slice i
//  tail_x/tail_y in   N*XW/N*YW   next-step tail coords
//  otail_x/otail_y in N*XW/N*YW   current (old) tail coords
//  len_nxt       in   N*LW        next-step lengths
//  tile_rd_en    out  1           tile read strobe
//  tile_rd_x/y   out  XW/YW       tile read address (current map)
//  tile_rd_data  in   tile_t      tile at address, valid cycle after tile_rd_en
//  busy          out  1           high from start acceptance until done
//  done          out  1           1-cycle pulse: results valid
//  eaten         out  NUM_SNAKES  snake i's new head lands on POINT
//  died          out  NUM_SNAKES  snake i dies this step
//  winner_valid  out  1           exactly one winner
//  winner        out  $clog2(N)   winner index
//  draw          out  1           game ends with no winner
// BEHAVIOUR
//  Reset: state IDLE; busy, done, tile_rd_en, eaten, died, winner_valid, winner, draw all 0. Reset mid-scan aborts, no done.
//  FSM IDLE->PAIR->TILE->RESOLVE->IDLE.
//   IDLE: start&game_active -> latch all geometry + alive_in into regs (inputs may change afterwards), busy=1.
//   PAIR (1 cycle): bump[i] = alive i,j, j!=i, head_i==head_j (both get bump); htail[i] = head_i==tail_j for any alive j incl. i.
//   TILE: issue read for snake k=0..N-1 on consecutive cycles at (head_x[k],head_y[k]); dead snakes still read, result ignored.
//     Data for k captured cycle after issue: POINT->eat[k]; WALL->wall[k];
//     SNAKE owner j (alive) and head_k != otail_j -> body[k]. TILE lasts N+1 cycles.
//   RESOLVE (1 cycle): died[i]=alive&(bump|htail|wall|body); eaten[i]=alive&eat&~died[i];
//     surv=alive&~died; long[i]=surv&(len_nxt==MAX_LEN).
//     Verdict priority: surv==0 & alive!=0 -> draw; |long: one -> winner, >1 -> draw;
//     popcount(alive)>1 & popcount(surv)==1 -> winner=that index; else neither.
//  Outputs registered on RESOLVE->IDLE; done pulses, busy drops same cycle.
//  Latency fixed: done exactly N+3 cycles after the cycle start is sampled.
//  Results hold until next accepted start, then eaten/died/verdict clear to 0.
//  start while busy or game_active=0: ignored, no effect. game_active falling mid-scan: scan completes.
//  winner_valid and draw never both 1.
// STRUCTURE
//  snake_pkg gains: tile_kind_e (EMPTY,WALL,POINT,SNAKE), tile_t {kind, owner[1:0]}, MAX_SNAKES=4, coord typedefs.
//  Sub-module collision_verdict: comb surv/long/popcount -> winner_valid, winner, draw; unit-testable.
//  Engine: FSM, latch regs, pair comparator, read sequencer, per-snake flag regs.
// TESTING
//  N=2, s0 head (5,5) on POINT, s1 clear -> done at cycle 5, eaten=01, died=00, no verdict.
//  N=2, heads both (7,3) -> died=11, draw=1, winner_valid=0.
//  N=2, s0 head on WALL, s1 clear -> died=01, winner_valid=1, winner=1.
//  s0 head on s1 body tile == s1 otail -> died=00; same tile != otail -> died=01.
//  N=4, alive=1011, s2 head == s0 head (s2 dead) -> no bump; s3 len_nxt=MAX_LEN -> winner=3.
//  start repeated while busy -> ignored, one done; rst mid-TILE -> busy=0, no done, outputs 0.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared snake game types: map tiles, coordinates and small helpers.
// Used by the collision engine and its verdict logic.
package snake_pkg;

  localparam int MAX_SNAKES = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    WALL  = 2'd1,
    POINT = 2'd2,
    SNAKE = 2'd3
  } tile_kind_e;

  typedef struct packed {
    tile_kind_e kind;
    logic [1:0] owner;
  } tile_t;

  typedef logic [5:0] coord_x_t;
  typedef logic [4:0] coord_y_t;

  function automatic logic [2:0] popcnt(
    input logic [MAX_SNAKES-1:0] v
  );
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < MAX_SNAKES; i++)
      n = n + {2'b00, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/collision_verdict.sv
// Game verdict from one step's alive/died/length flags.
// Pure combinational so it can be exercised on its own.
module collision_verdict
  import snake_pkg::*;
#(
  parameter int NUM_SNAKES = 2,
  localparam int WW = $clog2(NUM_SNAKES)
) (
  input  logic [NUM_SNAKES-1:0] alive,
  input  logic [NUM_SNAKES-1:0] died,
  input  logic [NUM_SNAKES-1:0] len_hit,
  output logic                  winner_valid,
  output logic [WW-1:0]         winner,
  output logic                  draw
);

  logic [NUM_SNAKES-1:0] surv;
  logic [NUM_SNAKES-1:0] lng;
  logic [2:0]            n_alive;
  logic [2:0]            n_surv;
  logic [2:0]            n_long;
  logic [WW-1:0]         surv_idx;
  logic [WW-1:0]         long_idx;

  assign surv    = alive & ~died;
  assign lng     = surv & len_hit;
  assign n_alive = popcnt(MAX_SNAKES'(alive));
  assign n_surv  = popcnt(MAX_SNAKES'(surv));
  assign n_long  = popcnt(MAX_SNAKES'(lng));

  always_comb begin
    surv_idx = '0;
    long_idx = '0;
    for (int i = 0; i < NUM_SNAKES; i++) begin
      if (surv[i]) surv_idx = WW'(i);
      if (lng[i])  long_idx = WW'(i);
    end
  end

  // Mutual wipe-out beats a length win; two length wins tie.
  always_comb begin
    winner_valid = 1'b0;
    winner       = '0;
    draw         = 1'b0;
    if (surv == '0 && alive != '0) begin
      draw = 1'b1;
    end else if (lng != '0) begin
      if (n_long == 3'd1) begin
        winner_valid = 1'b1;
        winner       = long_idx;
      end else begin
        draw = 1'b1;
      end
    end else if (n_alive > 3'd1 && n_surv == 3'd1) begin
      winner_valid = 1'b1;
      winner       = surv_idx;
    end
  end

endmodule

// File: rtl/collision_engine.sv
// Per-step collision and score judge for up to four snakes.
// Latches geometry, pairs heads, scans one map tile per snake, then resolves.
module collision_engine
  import snake_pkg::*;
#(
  parameter int NUM_SNAKES = 2,
  parameter int XW         = 6,
  parameter int YW         = 5,
  parameter int LW         = 8,
  parameter int MAX_LEN    = 64,
  localparam int WW = $clog2(NUM_SNAKES)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     game_active,
  input  logic [NUM_SNAKES-1:0]    alive_in,
  input  logic [NUM_SNAKES*XW-1:0] head_x,
  input  logic [NUM_SNAKES*YW-1:0] head_y,
  input  logic [NUM_SNAKES*XW-1:0] tail_x,
  input  logic [NUM_SNAKES*YW-1:0] tail_y,
  input  logic [NUM_SNAKES*XW-1:0] otail_x,
  input  logic [NUM_SNAKES*YW-1:0] otail_y,
  input  logic [NUM_SNAKES*LW-1:0] len_nxt,
  output logic                     tile_rd_en,
  output logic [XW-1:0]            tile_rd_x,
  output logic [YW-1:0]            tile_rd_y,
  input  tile_t                    tile_rd_data,
  output logic                     busy,
  output logic                     done,
  output logic [NUM_SNAKES-1:0]    eaten,
  output logic [NUM_SNAKES-1:0]    died,
  output logic                     winner_valid,
  output logic [WW-1:0]            winner,
  output logic                     draw
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PAIR = 2'd1;
  localparam logic [1:0] S_TILE = 2'd2;
  localparam logic [1:0] S_RES  = 2'd3;
  localparam int CW = $clog2(NUM_SNAKES + 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          accept;

  logic [XW-1:0] hx_q [NUM_SNAKES];
  logic [YW-1:0] hy_q [NUM_SNAKES];
  logic [XW-1:0] tx_q [NUM_SNAKES];
  logic [YW-1:0] ty_q [NUM_SNAKES];
  logic [XW-1:0] ox_q [NUM_SNAKES];
  logic [YW-1:0] oy_q [NUM_SNAKES];
  logic [LW-1:0] ln_q [NUM_SNAKES];
  logic [NUM_SNAKES-1:0] alv_q;

  logic [NUM_SNAKES-1:0] bump_q, htail_q;
  logic [NUM_SNAKES-1:0] eat_q, wall_q, body_q;
  logic [NUM_SNAKES-1:0] bump_c, htail_c;
  logic [NUM_SNAKES-1:0] cap_sel;
  logic [NUM_SNAKES-1:0] died_c, eaten_c, len_hit;

  logic          cap_en;
  logic [XW-1:0] cap_hx;
  logic [YW-1:0] cap_hy;
  logic          hit_eat, hit_wall, hit_body;

  logic          vd_valid, vd_draw;
  logic [WW-1:0] vd_winner;

  assign accept = (state == S_IDLE) && start && game_active;

  always_ff @(posedge clk) begin
    if (accept) begin
      alv_q <= alive_in;
      for (int i = 0; i < NUM_SNAKES; i++) begin
        hx_q[i] <= head_x[i*XW +: XW];
        hy_q[i] <= head_y[i*YW +: YW];
        tx_q[i] <= tail_x[i*XW +: XW];
        ty_q[i] <= tail_y[i*YW +: YW];
        ox_q[i] <= otail_x[i*XW +: XW];
        oy_q[i] <= otail_y[i*YW +: YW];
        ln_q[i] <= len_nxt[i*LW +: LW];
      end
    end
  end

  // Head bumps are symmetric; own next tail counts as a hit too.
  always_comb begin
    bump_c  = '0;
    htail_c = '0;
    for (int i = 0; i < NUM_SNAKES; i++) begin
      for (int j = 0; j < NUM_SNAKES; j++) begin
        if (alv_q[j] && j != i &&
            hx_q[i] == hx_q[j] && hy_q[i] == hy_q[j])
          bump_c[i] = 1'b1;
        if (alv_q[j] &&
            hx_q[i] == tx_q[j] && hy_q[i] == ty_q[j])
          htail_c[i] = 1'b1;
      end
    end
  end

  assign tile_rd_en = (state == S_TILE) &&
                      (cnt < CW'(NUM_SNAKES));
  assign cap_en     = (state == S_TILE) && (cnt != '0);

  always_comb begin
    tile_rd_x = '0;
    tile_rd_y = '0;
    cap_hx    = '0;
    cap_hy    = '0;
    cap_sel   = '0;
    for (int i = 0; i < NUM_SNAKES; i++) begin
      if (cnt == CW'(i)) begin
        tile_rd_x = hx_q[i];
        tile_rd_y = hy_q[i];
      end
      if (cnt == CW'(i + 1)) begin
        cap_hx     = hx_q[i];
        cap_hy     = hy_q[i];
        cap_sel[i] = 1'b1;
      end
    end
  end

  // A body tile that is an old tail is vacated this step.
  always_comb begin
    hit_eat  = tile_rd_data.kind == POINT;
    hit_wall = tile_rd_data.kind == WALL;
    hit_body = 1'b0;
    for (int j = 0; j < NUM_SNAKES; j++) begin
      if (tile_rd_data.kind == SNAKE &&
          tile_rd_data.owner == 2'(j) && alv_q[j] &&
          (cap_hx != ox_q[j] || cap_hy != oy_q[j]))
        hit_body = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SNAKES; i++)
      len_hit[i] = ln_q[i] == LW'(MAX_LEN);
  end

  assign died_c  = alv_q &
                   (bump_q | htail_q | wall_q | body_q);
  assign eaten_c = alv_q & eat_q & ~died_c;

  collision_verdict #(
    .NUM_SNAKES(NUM_SNAKES)
  ) u_verdict (
    .alive        (alv_q),
    .died         (died_c),
    .len_hit      (len_hit),
    .winner_valid (vd_valid),
    .winner       (vd_winner),
    .draw         (vd_draw)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      eaten        <= '0;
      died         <= '0;
      winner_valid <= 1'b0;
      winner       <= '0;
      draw         <= 1'b0;
      bump_q       <= '0;
      htail_q      <= '0;
      eat_q        <= '0;
      wall_q       <= '0;
      body_q       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            state        <= S_PAIR;
            busy         <= 1'b1;
            eaten        <= '0;
            died         <= '0;
            winner_valid <= 1'b0;
            winner       <= '0;
            draw         <= 1'b0;
            eat_q        <= '0;
            wall_q       <= '0;
            body_q       <= '0;
          end
        end
        S_PAIR: begin
          bump_q  <= bump_c;
          htail_q <= htail_c;
          cnt     <= '0;
          state   <= S_TILE;
        end
        S_TILE: begin
          if (cap_en) begin
            for (int i = 0; i < NUM_SNAKES; i++) begin
              if (cap_sel[i]) begin
                eat_q[i]  <= hit_eat;
                wall_q[i] <= hit_wall;
                body_q[i] <= hit_body;
              end
            end
          end
          if (cnt == CW'(NUM_SNAKES)) begin
            state <= S_RES;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_RES: begin
          died         <= died_c;
          eaten        <= eaten_c;
          winner_valid <= vd_valid;
          winner       <= vd_winner;
          draw         <= vd_draw;
          done         <= 1'b1;
          busy         <= 1'b0;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
